mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 datapath mux (`Control[1:0]`, Y = A/B/C/D for 00/01/10/11) among four requesters.
- Issues a registered one-hot grant and drives the mux select.
- Bounds each requester's tenure to a configurable burst length, using a downstream `Ready` handshake to count beats.
- Sits between the four source blocks and the mux select input.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant tenure; legal range 1..255.
- CNT_W, 8, width of the beat counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Req  input  4  request per source; bit i = source i (mux input A,B,C,D).
- Ready  input  1  downstream accepts the current mux output this cycle.
- Grant  output  4  registered one-hot grant; all zero when idle.
- Control  output  2  mux select, the binary index of the granted source.
- Valid  output  1  mux output is valid (= |Grant).
- Beat  output  1  beat accepted this cycle (Valid & Ready).

Behaviour:
- Reset: asynchronous on rst_n low; the outputs and internal state take these values:
  - Grant=4'b0000, Control=2'b00, Valid=0, Beat=0.
  - Priority pointer ptr=0, beat counter cnt=0, state=IDLE.
- Release is synchronous; the first grant can appear on the first rising edge after rst_n rises.
- State IDLE:
  - If Req != 0, pick the winner on the edge.
  - Winner = first set bit of Req scanning ptr, ptr+1, ... mod 4.
  - Next state GRANT; Grant=onehot(winner), Control=winner, cnt=0.
  - Latency from Req to Grant: exactly 1 clock.
- State GRANT, with g = granted index:
  - Beat is combinational: Valid & Ready.
  - Each Beat increments cnt; no increment when Ready=0 (stall); Grant and Control hold.
  - Release condition (evaluated each cycle): Req[g]=0, or (Beat and cnt==MAX_BURST-1).
  - On release: ptr_next=(g+1) mod 4; re-arbitrate in the same edge using the current Req with ptr_next.
    - If a winner exists: stay in GRANT with the new winner and cnt=0. There is no idle bubble between tenures.
    - If no winner exists: go to IDLE; Grant=0, Valid=0.
  - If g is the only requester and hits MAX_BURST, it is re-granted (cnt=0) with ptr advanced past it.
- Req[g] dropping while Ready=0 still releases; the unaccepted beat is abandoned (source responsibility).
- Control holds its last value in IDLE (mux select stable, no glitch); it changes only on a new grant.
- A Req bit rising mid-tenure never pre-empts; it is considered only at release.
- Fairness: any continuously asserted Req is granted within 3 tenures.
- Grant is always one-hot or zero; `Control` always equals the index of the set Grant bit when Valid=1.
- Reset asserted mid-tenure aborts immediately to reset values.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - Adds input port `Lock` (1 bit).
  - While in GRANT with Lock=1, the MAX_BURST release is suppressed; cnt saturates at MAX_BURST-1.
  - Release then occurs only on Req[g]=0, or on the first Beat after Lock falls with cnt at MAX_BURST-1.
  - Lock is ignored in IDLE.
- When undefined: no Lock port; burst limit always enforced.

Test Plan:
- Reset then Req=4'b0001, Ready=1, MAX_BURST=4 -> Grant=0001 and Control=00 one cycle later; 4 Beats; then re-grant of source 0 (sole requester), cnt restarts.
- Req=4'b1111 held, Ready=1 -> grants rotate 0,1,2,3,0, each held exactly 4 cycles, no idle cycle between tenures; Control follows 00,01,10,11,00.
- Source 2 granted, Ready=0 for 10 cycles -> Grant=0100 held, cnt unchanged; after Ready=1, exactly 4 Beats before release.
- Source 1 granted, Req[1] drops after 2 Beats with Req=4'b1000 pending -> next cycle Grant=1000, Control=11; with Req=0 -> Valid=0, Control stays 01.
- Assert rst_n=0 mid-tenure (asynchronously, between edges) -> Grant=0, Valid=0, Control=00 immediately; after release, with Req=4'b0110, source 1 is granted first (ptr=0).
- ARB_LOCK_EN defined, Lock=1 for 10 Beats on source 3 with Req=1111 -> no release during Lock; release on first Beat after Lock falls; next grant is source 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux: registered one-hot grant, mux select
// and a per-tenure beat limit. Define ARB_LOCK_EN to add the Lock input that stretches a tenure.
module mux4_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Req,
    input  logic       Ready,
`ifdef ARB_LOCK_EN
    input  logic       Lock,
`endif
    output logic [3:0] Grant,
    output logic [1:0] Control,
    output logic       Valid,
    output logic       Beat
);

    typedef enum logic {IDLE, GRANT} state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    state_e           state_q;
    logic [3:0]       grant_q;
    logic [1:0]       control_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    pick_t            idle_pick;
    pick_t            rel_pick;
    logic [1:0]       ptr_next;
    logic             cnt_last;
    logic             hold_tenure;
    logic             release_now;

    // First set request bit scanning from ptr upward, wrapping at 4.
    function automatic pick_t pick(input logic [3:0] req, input logic [1:0] ptr);
        pick_t      r;
        logic [1:0] k;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            k = ptr + 2'(i);
            if (!r.found && req[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

    assign Grant   = grant_q;
    assign Control = control_q;
    assign Valid   = |grant_q;
    assign Beat    = Valid & Ready;

`ifdef ARB_LOCK_EN
    assign hold_tenure = Lock;
`else
    assign hold_tenure = 1'b0;
`endif

    // In GRANT, Control is the granted index, so it doubles as g.
    assign ptr_next    = control_q + 2'd1;
    assign cnt_last    = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign release_now = !Req[control_q] || (Beat && cnt_last && !hold_tenure);
    assign idle_pick   = pick(Req, ptr_q);
    assign rel_pick    = pick(Req, ptr_next);

    // NOTE: every state register uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            control_q <= 2'b00;
            ptr_q     <= 2'b00;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (idle_pick.found) begin
                        state_q   <= GRANT;
                        grant_q   <= 4'b0001 << idle_pick.idx;
                        control_q <= idle_pick.idx;
                        cnt_q     <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        ptr_q <= ptr_next;
                        cnt_q <= '0;
                        if (rel_pick.found) begin
                            grant_q   <= 4'b0001 << rel_pick.idx;
                            control_q <= rel_pick.idx;
                        end else begin
                            // Control keeps its value so the mux select stays put while idle.
                            state_q <= IDLE;
                            grant_q <= 4'b0000;
                        end
                    end else if (Beat && !cnt_last) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed-vector bench for mux4_rr_arbiter (MAX_BURST=4); lock scenario runs when ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Req;
    logic       Ready;
    logic       Lock;
    logic [3:0] Grant;
    logic [1:0] Control;
    logic       Valid;
    logic       Beat;

    int checks   = 0;
    int failures = 0;

    mux4_rr_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Req     (Req),
        .Ready   (Ready),
`ifdef ARB_LOCK_EN
        .Lock    (Lock),
`endif
        .Grant   (Grant),
        .Control (Control),
        .Valid   (Valid),
        .Beat    (Beat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int idx);
        check({tag, "_grant"}, Grant, 32'(4'b0001 << idx));
        check({tag, "_ctrl"}, Control, 32'(idx));
        check({tag, "_valid"}, Valid, 1);
    endtask

    task automatic do_reset();
        Req   = 4'b0000;
        Ready = 1'b0;
        Lock  = 1'b0;
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Req   = 4'b0000;
        Ready = 1'b0;
        Lock  = 1'b0;
        rst_n = 1'b1;
        #2;

        // Reset values
        do_reset();
        check("rst_grant", Grant, 0);
        check("rst_ctrl", Control, 0);
        check("rst_valid", Valid, 0);
        check("rst_beat", Beat, 0);

        // Sole requester 0: grant after 1 clock, re-granted after 4 beats with cnt restarted
        Req = 4'b0001; Ready = 1'b1;
        tick();
        check_grant("t1_first", 0);
        check("t1_beat", Beat, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_grant("t1_hold", 0);
        end
        Req = 4'b0011;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_grant("t1_restart", 0);
        end
        tick();
        check_grant("t1_next", 1);

        // All requesting: 0,1,2,3,0 each held 4 cycles, no bubble
        do_reset();
        Req = 4'b1111; Ready = 1'b1;
        tick();
        check_grant("t2_k0", 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_grant("t2_rot", (k / 4) % 4);
        end

        // Source 2 stalled 10 cycles, then exactly 4 beats
        do_reset();
        Req = 4'b1100; Ready = 1'b0;
        tick();
        check_grant("t3_first", 2);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_grant("t3_stall", 2);
            check("t3_beat0", Beat, 0);
        end
        Ready = 1'b1;
        #1;
        check("t3_beat1", Beat, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_grant("t3_run", 2);
        end
        tick();
        check_grant("t3_rel", 3);

        // Source 1 drops after 2 beats with source 3 pending
        do_reset();
        Req = 4'b0010; Ready = 1'b1;
        tick(); tick(); tick();
        check_grant("t4_pre", 1);
        Req = 4'b1000;
        tick();
        check_grant("t4_handoff", 3);

        // Source 1 drops with nobody pending: idle, Control holds 01
        do_reset();
        Req = 4'b0010; Ready = 1'b1;
        tick(); tick(); tick();
        Req = 4'b0000;
        tick();
        check("t4_idle_grant", Grant, 0);
        check("t4_idle_valid", Valid, 0);
        check("t4_idle_ctrl", Control, 1);
        check("t4_idle_beat", Beat, 0);
        tick();
        check("t4_idle_ctrl2", Control, 1);

        // Asynchronous reset mid-tenure, then ptr restarts at 0
        Req = 4'b1000;
        tick(); tick();
        check_grant("t5_pre", 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_grant", Grant, 0);
        check("t5_async_valid", Valid, 0);
        check("t5_async_ctrl", Control, 0);
        Req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_grant("t5_after", 1);

`ifdef ARB_LOCK_EN
        // Lock held for 10 beats on source 3, release on first beat after Lock falls
        do_reset();
        Req = 4'b1000; Ready = 1'b1; Lock = 1'b1;
        tick();
        check_grant("t6_first", 3);
        Req = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_grant("t6_locked", 3);
        end
        Lock = 1'b0;
        tick();
        check_grant("t6_rel", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
